// File: rtl/uart_cmd_parser_if.sv
// Byte-stream and command bundle between the UART receiver, the frame parser and the command consumer.
interface uart_cmd_parser_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] cmd;
    logic              cmd_valid;
    logic              link_ok;
    logic              frame_err;
    logic [7:0]        err_count;

    modport master (
        output rx_data,
        output rx_valid,
        input  cmd,
        input  cmd_valid,
        input  link_ok,
        input  frame_err,
        input  err_count
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output cmd,
        output cmd_valid,
        output link_ok,
        output frame_err,
        output err_count
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Recognises START/CMD/STOP frames from the UART byte stream, publishes the latched command
// and falls back to a failsafe command when no good frame has arrived for too long.
module uart_cmd_parser #(
    parameter int                DATA_W           = 8,
    parameter logic [DATA_W-1:0] START_BYTE       = 8'h0A,
    parameter logic [DATA_W-1:0] STOP_BYTE        = 8'h08,
    parameter logic [DATA_W-1:0] CMD_MAX          = 8'h0F,
    parameter logic [DATA_W-1:0] FAILSAFE_CMD     = 8'h00,
    parameter int                BYTE_TIMEOUT_CYC = 50000,
    parameter int                LINK_TIMEOUT_CYC = 25000000
) (
    input logic             clk,
    input logic             rst,
    uart_cmd_parser_if.slave bus
);
    localparam int BT_W = $clog2(BYTE_TIMEOUT_CYC) + 1;
    localparam int LT_W = $clog2(LINK_TIMEOUT_CYC) + 1;
    localparam logic [BT_W-1:0] BT_MAX  = BT_W'(BYTE_TIMEOUT_CYC);
    localparam logic [LT_W-1:0] LT_MAX  = LT_W'(LINK_TIMEOUT_CYC);
    localparam logic [LT_W-1:0] LT_FIRE = LT_W'(LINK_TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_CMD,
        WAIT_STOP
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] pending;
    logic [DATA_W-1:0] cmd_r;
    logic              cmd_valid_r;
    logic              link_ok_r;
    logic              frame_err_r;
    logic [7:0]        err_count_r;
    logic [BT_W-1:0]   byte_cnt;
    logic [LT_W-1:0]   link_cnt;

    logic is_start;
    logic is_stop;
    logic cmd_legal;
    logic byte_timeout;
    logic good_frame;
    logic bad_frame;

    function automatic logic [7:0] err_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [BT_W-1:0] byte_cnt_inc(input logic [BT_W-1:0] v);
        return (v >= BT_MAX) ? BT_MAX : v + BT_W'(1);
    endfunction

    function automatic logic [LT_W-1:0] link_cnt_inc(input logic [LT_W-1:0] v);
        return (v >= LT_MAX) ? LT_MAX : v + LT_W'(1);
    endfunction

    // A byte arriving in the same cycle as the timeout wins, so the timeout only counts idle cycles.
    always_comb begin
        is_start     = (bus.rx_data == START_BYTE);
        is_stop      = (bus.rx_data == STOP_BYTE);
        cmd_legal    = (bus.rx_data <= CMD_MAX);
        byte_timeout = !bus.rx_valid && (byte_cnt == BT_MAX);
        good_frame   = (state == WAIT_STOP) && bus.rx_valid && is_stop;
        bad_frame    = 1'b0;
        case (state)
            WAIT_CMD:  bad_frame = (bus.rx_valid && !cmd_legal) || byte_timeout;
            WAIT_STOP: bad_frame = (bus.rx_valid && !is_stop) || byte_timeout;
            default:   bad_frame = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= '0;
            cmd_r       <= FAILSAFE_CMD;
            cmd_valid_r <= 1'b0;
            link_ok_r   <= 1'b0;
            frame_err_r <= 1'b0;
            err_count_r <= 8'd0;
            byte_cnt    <= '0;
            link_cnt    <= '0;
        end else begin
            cmd_valid_r <= 1'b0;
            frame_err_r <= bad_frame;
            if (bad_frame) begin
                err_count_r <= err_inc(err_count_r);
            end

            case (state)
                IDLE: begin
                    byte_cnt <= '0;
                    if (bus.rx_valid && is_start) begin
                        state <= WAIT_CMD;
                    end
                end
                WAIT_CMD: begin
                    if (bus.rx_valid) begin
                        byte_cnt <= '0;
                        if (cmd_legal) begin
                            pending <= bus.rx_data;
                            state   <= WAIT_STOP;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (byte_timeout) begin
                        byte_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        byte_cnt <= byte_cnt_inc(byte_cnt);
                    end
                end
                WAIT_STOP: begin
                    if (bus.rx_valid) begin
                        byte_cnt <= '0;
                        // A START in place of STOP is taken as the beginning of a fresh frame.
                        if (is_stop) begin
                            state <= IDLE;
                        end else if (is_start) begin
                            state <= WAIT_CMD;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (byte_timeout) begin
                        byte_cnt <= '0;
                        pending  <= '0;
                        state    <= IDLE;
                    end else begin
                        byte_cnt <= byte_cnt_inc(byte_cnt);
                    end
                end
                default: begin
                    byte_cnt <= '0;
                    state    <= IDLE;
                end
            endcase

            // A good frame takes priority over a watchdog expiry in the same cycle.
            if (good_frame) begin
                cmd_r       <= pending;
                cmd_valid_r <= 1'b1;
                link_ok_r   <= 1'b1;
                link_cnt    <= '0;
            end else begin
                link_cnt <= link_cnt_inc(link_cnt);
                if (link_ok_r && (link_cnt == LT_FIRE)) begin
                    link_ok_r   <= 1'b0;
                    cmd_r       <= FAILSAFE_CMD;
                    cmd_valid_r <= 1'b1;
                end
            end
        end
    end

    assign bus.cmd       = cmd_r;
    assign bus.cmd_valid = cmd_valid_r;
    assign bus.link_ok   = link_ok_r;
    assign bus.frame_err = frame_err_r;
    assign bus.err_count = err_count_r;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: fixed vector table, hand-timed corner sequences and random bytes
// checked cycle by cycle against a partial-frame/timestamp reference model.
module tb_uart_cmd_parser;
    localparam int         BT    = 100;
    localparam int         LT    = 1000;
    localparam logic [7:0] START = 8'h0A;
    localparam logic [7:0] STOP  = 8'h08;
    localparam logic [7:0] CMAX  = 8'h0F;
    localparam logic [7:0] FS    = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_parser_if #(.DATA_W(8)) bus ();

    uart_cmd_parser #(
        .BYTE_TIMEOUT_CYC(BT),
        .LINK_TIMEOUT_CYC(LT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the bytes of the frame in progress plus cycle stamps of events.
    logic [7:0] m_frame[$];
    int         m_cyc       = 0;
    int         m_last      = 0;
    int         m_last_good = 0;
    logic [7:0] m_cmd       = FS;
    logic [7:0] m_errc      = 8'd0;
    logic       m_cv        = 1'b0;
    logic       m_link      = 1'b0;
    logic       m_fe        = 1'b0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [7:0] cmd;
        logic       cv;
        logic       link;
        logic       fe;
        logic [7:0] ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [7:0] cmd,
                                input logic cv, input logic link, input logic fe,
                                input logic [7:0] ec);
        vec_t t;
        t.v = v; t.d = d; t.cmd = cmd; t.cv = cv; t.link = link; t.fe = fe; t.ec = ec;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_err();
        m_fe = 1'b1;
        if (m_errc != 8'hFF) m_errc = m_errc + 8'd1;
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [7:0] d);
        logic good;
        good = 1'b0;
        m_cv = 1'b0;
        m_fe = 1'b0;
        if (r) begin
            m_frame.delete();
            m_cmd  = FS;
            m_link = 1'b0;
            m_errc = 8'd0;
            return;
        end
        m_cyc++;
        if (v) begin
            if (m_frame.size() == 0) begin
                if (d == START) begin
                    m_frame.push_back(d);
                    m_last = m_cyc;
                end
            end else if (m_frame.size() == 1) begin
                if (d <= CMAX) begin
                    m_frame.push_back(d);
                    m_last = m_cyc;
                end else begin
                    model_err();
                    m_frame.delete();
                end
            end else begin
                if (d == STOP) begin
                    good        = 1'b1;
                    m_cmd       = m_frame[1];
                    m_cv        = 1'b1;
                    m_link      = 1'b1;
                    m_last_good = m_cyc;
                    m_frame.delete();
                end else begin
                    model_err();
                    m_frame.delete();
                    if (d == START) begin
                        m_frame.push_back(d);
                        m_last = m_cyc;
                    end
                end
            end
        end else if (m_frame.size() != 0 && (m_cyc - m_last) > BT) begin
            model_err();
            m_frame.delete();
        end
        if (!good && m_link && (m_cyc - m_last_good) == LT) begin
            m_link = 1'b0;
            m_cmd  = FS;
            m_cv   = 1'b1;
        end
    endtask

    // One clock edge: drive on the falling edge, update model at the rising edge, sample 1 ns later.
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        @(negedge clk);
        rst          = r;
        bus.rx_valid = v;
        bus.rx_data  = d;
        @(posedge clk);
        model_edge(r, v, d);
        #1;
        chk("model", {bus.cmd, bus.cmd_valid, bus.link_ok, bus.frame_err, bus.err_count},
            {m_cmd, m_cv, m_link, m_fe, m_errc});
    endtask

    initial begin
        int first;
        int cv_cnt;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("reset_cmd", bus.cmd, FS);
        chk("reset_cv", bus.cmd_valid, 0);
        chk("reset_link", bus.link_ok, 0);
        chk("reset_fe", bus.frame_err, 0);
        chk("reset_ec", bus.err_count, 0);

        // v, byte -> expected cmd, cmd_valid, link_ok, frame_err, err_count after the edge
        tbl.push_back(mk(1, 8'h0A, 8'h00, 0, 0, 0, 8'd0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 8'd0));
        tbl.push_back(mk(1, 8'h04, 8'h00, 0, 0, 0, 8'd0));
        tbl.push_back(mk(1, 8'h08, 8'h04, 1, 1, 0, 8'd0));
        tbl.push_back(mk(1, 8'h0A, 8'h04, 0, 1, 0, 8'd0));
        tbl.push_back(mk(1, 8'h04, 8'h04, 0, 1, 0, 8'd0));
        tbl.push_back(mk(1, 8'h05, 8'h04, 0, 1, 1, 8'd1));
        tbl.push_back(mk(1, 8'h0A, 8'h04, 0, 1, 0, 8'd1));
        tbl.push_back(mk(1, 8'h04, 8'h04, 0, 1, 0, 8'd1));
        tbl.push_back(mk(1, 8'h0A, 8'h04, 0, 1, 1, 8'd2));
        tbl.push_back(mk(1, 8'h07, 8'h04, 0, 1, 0, 8'd2));
        tbl.push_back(mk(1, 8'h08, 8'h07, 1, 1, 0, 8'd2));
        tbl.push_back(mk(1, 8'h0A, 8'h07, 0, 1, 0, 8'd2));
        tbl.push_back(mk(1, 8'h10, 8'h07, 0, 1, 1, 8'd3));
        tbl.push_back(mk(1, 8'h08, 8'h07, 0, 1, 0, 8'd3));
        tbl.push_back(mk(1, 8'h0A, 8'h07, 0, 1, 0, 8'd3));
        tbl.push_back(mk(1, 8'h0A, 8'h07, 0, 1, 0, 8'd3));
        tbl.push_back(mk(1, 8'h08, 8'h0A, 1, 1, 0, 8'd3));
        foreach (tbl[i]) begin
            step(1'b0, tbl[i].v, tbl[i].d);
            chk($sformatf("vec%0d", i),
                {bus.cmd, bus.cmd_valid, bus.link_ok, bus.frame_err, bus.err_count},
                {tbl[i].cmd, tbl[i].cv, tbl[i].link, tbl[i].fe, tbl[i].ec});
        end

        // Byte timeout: frame_err 101 cycles after the lone START.
        step(1'b0, 1'b1, START);
        first = -1;
        for (int k = 1; k <= 150; k++) begin
            step(1'b0, 1'b0, 8'h00);
            if (bus.frame_err && first < 0) first = k;
        end
        chk("byte_timeout_at", first, BT + 1);
        chk("byte_timeout_ec", bus.err_count, 4);
        cv_cnt = 0;
        step(1'b0, 1'b1, 8'h04);
        if (bus.cmd_valid) cv_cnt++;
        step(1'b0, 1'b1, STOP);
        if (bus.cmd_valid) cv_cnt++;
        chk("orphan_bytes_cv", cv_cnt, 0);
        chk("orphan_bytes_cmd", bus.cmd, 8'h0A);

        // Link loss: failsafe exactly LT cycles after the good frame's cmd_valid.
        step(1'b0, 1'b1, START);
        step(1'b0, 1'b1, 8'h04);
        step(1'b0, 1'b1, STOP);
        chk("pre_loss_cmd", bus.cmd, 8'h04);
        first  = -1;
        cv_cnt = 0;
        for (int k = 1; k <= LT + 200; k++) begin
            step(1'b0, 1'b0, 8'h00);
            if (bus.cmd_valid) begin
                cv_cnt++;
                if (first < 0) first = k;
            end
        end
        chk("failsafe_at", first, LT);
        chk("failsafe_pulses", cv_cnt, 1);
        chk("failsafe_link", bus.link_ok, 0);
        chk("failsafe_cmd", bus.cmd, FS);
        step(1'b0, 1'b1, START);
        step(1'b0, 1'b1, 8'h03);
        step(1'b0, 1'b1, STOP);
        chk("recover_link", bus.link_ok, 1);
        chk("recover_cmd", bus.cmd, 8'h03);

        // STOP lands exactly on the watchdog expiry cycle: the frame wins.
        cv_cnt = 0;
        for (int k = 1; k <= LT - 3; k++) begin
            step(1'b0, 1'b0, 8'h00);
            if (bus.cmd_valid) cv_cnt++;
        end
        step(1'b0, 1'b1, START);
        step(1'b0, 1'b1, 8'h05);
        step(1'b0, 1'b1, STOP);
        chk("race_quiet_cv", cv_cnt, 0);
        chk("race_cmd", {bus.cmd, bus.cmd_valid, bus.link_ok}, {8'h05, 1'b1, 1'b1});
        step(1'b0, 1'b0, 8'h00);
        chk("race_after", {bus.cmd, bus.cmd_valid, bus.link_ok}, {8'h05, 1'b0, 1'b1});

        // Reset mid-frame, then error counter saturation.
        step(1'b0, 1'b1, START);
        step(1'b0, 1'b1, 8'h04);
        step(1'b1, 1'b0, 8'h00);
        chk("midreset_out", {bus.cmd, bus.cmd_valid, bus.link_ok, bus.frame_err, bus.err_count},
            {FS, 1'b0, 1'b0, 1'b0, 8'd0});
        step(1'b0, 1'b1, STOP);
        chk("midreset_dropped", bus.cmd_valid, 0);
        for (int k = 0; k < 300; k++) begin
            step(1'b0, 1'b1, START);
            step(1'b0, 1'b1, 8'h10);
        end
        chk("ec_saturate", bus.err_count, 8'hFF);
        chk("ec_sat_fe", bus.frame_err, 1);

        // Random bytes, gaps around the byte timeout, occasional link loss and resets.
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 499) == 0) begin
                step(1'b1, 1'b0, 8'h00);
            end else if ($urandom_range(0, 199) == 0) begin
                for (int g = $urandom_range(990, 1010); g > 0; g--) step(1'b0, 1'b0, 8'h00);
            end else if ($urandom_range(0, 19) == 0) begin
                for (int g = $urandom_range(95, 105); g > 0; g--) step(1'b0, 1'b0, 8'h00);
            end else begin
                logic [7:0] d;
                case ($urandom_range(0, 5))
                    0, 1:    d = START;
                    2:       d = STOP;
                    3:       d = 8'($urandom_range(0, 15));
                    4:       d = 8'($urandom_range(0, 255));
                    default: d = 8'($urandom_range(14, 17));
                endcase
                step(1'b0, ($urandom_range(0, 9) < 6), d);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
